switch_debouncer: RTL



---
 rtl/switch_debouncer.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/switch_debouncer.sv
// -----------------------------------------------------------------------------
// switch_debouncer
//
// Input-conditioning stage for the lab slide switches. Each raw, asynchronous,
// bouncing switch bit is brought into the clk domain through a two-flop
// synchronizer and then debounced on its own. The clean level only follows
// the synchronized input after the input has disagreed with the clean level
// for DEBOUNCE_CYCLES consecutive clocks. Any agreement in between (a bounce
// or a glitch) clears the count, so the full qualification time starts again.
//
// Alongside the clean levels the block emits one-cycle rise/fall pulses per
// bit and a combined any_change pulse for downstream sequential logic.
//
// Ports
//   clk           in   1        system clock, all state updates on rising edge
//   rst           in   1        synchronous, active-high reset
//   switch_raw    in   N_BITS   raw asynchronous switch levels
//   switch_clean  out  N_BITS   debounced, registered switch levels
//   switch_rise   out  N_BITS   one-cycle pulse on a clean 0->1 transition
//   switch_fall   out  N_BITS   one-cycle pulse on a clean 1->0 transition
//   any_change    out  1        OR of all rise/fall pulses, same cycle
//
// Parameters
//   N_BITS           number of independent switch channels
//   DEBOUNCE_CYCLES  consecutive disagreeing clocks needed to flip (2..2^24)
//   CNT_W            per-bit counter width, derived from DEBOUNCE_CYCLES
//
// Latency: counting the edge that first captures a new raw level into the
// first synchronizer flop as edge 1, a held level appears on switch_clean at
// edge DEBOUNCE_CYCLES+2 (two edges of synchronizer, then DEBOUNCE_CYCLES
// edges of qualification, the last of which performs the flip).
//
// Every output is taken straight from a flop; there is no combinational path
// from switch_raw to any output.
// -----------------------------------------------------------------------------
module switch_debouncer #(
    parameter int N_BITS          = 8,
    parameter int DEBOUNCE_CYCLES = 1000000,
    localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_BITS-1:0] switch_raw,
    output logic [N_BITS-1:0] switch_clean,
    output logic [N_BITS-1:0] switch_rise,
    output logic [N_BITS-1:0] switch_fall,
    output logic              any_change
);

    // Terminal count: the edge on which the counter holds this value and the
    // input still disagrees is the DEBOUNCE_CYCLES-th disagreeing edge, so
    // the flip happens there. The counter therefore never goes past it.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    // Synchronizer chain. sync1 may go metastable; only sync2 is consumed.
    logic [N_BITS-1:0] sync1_q, sync1_d;
    logic [N_BITS-1:0] sync2_q, sync2_d;

    // Debounced level and the registered edge pulses.
    logic [N_BITS-1:0] clean_q, clean_d;
    logic [N_BITS-1:0] rise_q,  rise_d;
    logic [N_BITS-1:0] fall_q,  fall_d;
    logic              any_q,   any_d;

    // One disagreement counter per channel.
    logic [CNT_W-1:0]  cnt_q [N_BITS];
    logic [CNT_W-1:0]  cnt_d [N_BITS];

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // The synchronizer is a plain flop-to-flop chain: nothing may be
        // inserted between the two stages.
        sync1_d = switch_raw;
        sync2_d = sync1_q;

        // Hold the clean level, pulses default low every cycle.
        clean_d = clean_q;
        rise_d  = '0;
        fall_d  = '0;

        for (int i = 0; i < N_BITS; i++) begin
            cnt_d[i] = cnt_q[i];

            if (sync2_q[i] == clean_q[i]) begin
                // Input agrees with the clean level: any partial count is a
                // bounce or glitch and is thrown away.
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                // Disagreement has lasted the full qualification window:
                // adopt the new level and pulse in the same cycle that
                // switch_clean shows it.
                clean_d[i] = sync2_q[i];
                cnt_d[i]   = '0;
                rise_d[i]  = sync2_q[i];
                fall_d[i]  = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end
        end

        // Computed from the next pulse values so that the registered
        // any_change lines up with the registered rise/fall pulses.
        any_d = |(rise_d | fall_d);
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    // Reset wins over everything, including a flip that would otherwise have
    // landed on the same edge; a pending qualification is simply discarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            clean_q <= '0;
            rise_q  <= '0;
            fall_q  <= '0;
            any_q   <= 1'b0;
            for (int i = 0; i < N_BITS; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            clean_q <= clean_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            any_q   <= any_d;
            for (int i = 0; i < N_BITS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Outputs (all registered)
    // -------------------------------------------------------------------------
    assign switch_clean = clean_q;
    assign switch_rise  = rise_q;
    assign switch_fall  = fall_q;
    assign any_change   = any_q;

endmodule
